// File: rtl/clint.sv
// clint: core-local interruptor holding msip, mtimecmp and a prescaled mtime behind a valid/ready bus
module clint #(
  parameter int unsigned RTC_DIV = 50
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        timer_irpt_o,
  output logic        soft_irpt_o
);
  localparam logic [15:0] DIV_LAST = 16'(RTC_DIV - 1);
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d, timer_irpt_q, timer_irpt_d, ready_q;
  logic [31:0] rdata_q, rdata_d;
  logic [13:0] off;
  logic        tick, wr, sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
  logic        unused_addr;
  assign unused_addr = ^{mem_addr_i[31:16], mem_addr_i[1:0]};
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return m;
  endfunction
  always_comb begin
    off          = mem_addr_i[15:2];
    sel_msip     = off == 14'h0000;
    sel_cmp_lo   = off == 14'h1000;
    sel_cmp_hi   = off == 14'h1001;
    sel_time_lo  = off == 14'h2ffe;
    sel_time_hi  = off == 14'h2fff;
    wr           = mem_valid_i && (mem_wstrb_i != 4'h0);
    tick         = tick_cnt_q == DIV_LAST;
    tick_cnt_d   = tick ? 16'h0 : tick_cnt_q + 16'h1;
    msip_d       = (wr && sel_msip && mem_wstrb_i[0]) ? mem_wdata_i[0] : msip_q;
    mtimecmp_d   = {(wr && sel_cmp_hi) ? merge(mtimecmp_q[63:32], mem_wdata_i, mem_wstrb_i) : mtimecmp_q[63:32],
                    (wr && sel_cmp_lo) ? merge(mtimecmp_q[31:0], mem_wdata_i, mem_wstrb_i) : mtimecmp_q[31:0]};
    // a software write to mtime wins over the tick; the increment is simply skipped that cycle
    mtime_d      = (wr && (sel_time_lo || sel_time_hi)) ?
                   {sel_time_hi ? merge(mtime_q[63:32], mem_wdata_i, mem_wstrb_i) : mtime_q[63:32],
                    sel_time_lo ? merge(mtime_q[31:0], mem_wdata_i, mem_wstrb_i) : mtime_q[31:0]} :
                   tick ? mtime_q + 64'h1 : mtime_q;
    timer_irpt_d = mtime_q >= mtimecmp_q;
    rdata_d      = !mem_valid_i ? 32'h0 :
                   sel_msip     ? {31'h0, msip_q} :
                   sel_cmp_lo   ? mtimecmp_q[31:0] :
                   sel_cmp_hi   ? mtimecmp_q[63:32] :
                   sel_time_lo  ? mtime_q[31:0] :
                   sel_time_hi  ? mtime_q[63:32] : 32'h0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_q   <= 16'h0;
      mtime_q      <= 64'h0;
      mtimecmp_q   <= '1;
      msip_q       <= 1'b0;
      timer_irpt_q <= 1'b0;
      ready_q      <= 1'b0;
      rdata_q      <= 32'h0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      timer_irpt_q <= timer_irpt_d;
      ready_q      <= mem_valid_i;
      rdata_q      <= rdata_d;
    end
  end
  assign mem_rdata_o  = rdata_q;
  assign mem_ready_o  = ready_q;
  assign timer_irpt_o = timer_irpt_q;
  assign soft_irpt_o  = msip_q;
endmodule

// File: tb/tb_clint.sv
// tb_clint: scoreboard bench for clint with a divide-by-4 and a divide-by-1 instance on a shared bus
module tb_clint;
  logic        clk = 0, rst_n = 0, valid = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [3:0]  wstrb = 0;
  logic [31:0] rd4, rd1;
  logic        rdy4, rdy1, tirq4, tirq1, sirq4, sirq1;
  int          checks = 0, failures = 0, cyc = 0, r = 0;
  bit          sel = 0;
  typedef struct {int due; bit chk; logic [31:0] exp; logic [15:0] a;} ent_t;
  ent_t sb[$];

  clint #(.RTC_DIV(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(valid), .mem_addr_i(addr), .mem_wdata_i(wdata),
    .mem_wstrb_i(wstrb), .mem_rdata_o(rd4), .mem_ready_o(rdy4), .timer_irpt_o(tirq4), .soft_irpt_o(sirq4));
  clint #(.RTC_DIV(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .mem_valid_i(valid), .mem_addr_i(addr), .mem_wdata_i(wdata),
    .mem_wstrb_i(wstrb), .mem_rdata_o(rd1), .mem_ready_o(rdy1), .timer_irpt_o(tirq1), .soft_irpt_o(sirq1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic rdy;
    logic [31:0] rd;
    ent_t e;
    rdy = sel ? rdy1 : rdy4;
    rd  = sel ? rd1 : rd4;
    if (rdy) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ready cyc=%0d got ready=1 exp ready=0", cyc);
      end else begin
        e = sb.pop_front();
        if (e.due != cyc) begin
          failures++;
          $display("FAIL ready_latency a=%h got cyc=%0d exp cyc=%0d", e.a, cyc, e.due);
        end
        if (e.chk) begin
          checks++;
          if (rd !== e.exp) begin
            failures++;
            $display("FAIL rdata a=%h got=%h exp=%h", e.a, rd, e.exp);
          end
        end
      end
    end else begin
      checks++;
      if (rd !== 32'h0) begin
        failures++;
        $display("FAIL rdata_idle cyc=%0d got=%h exp=0", cyc, rd);
      end
      if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_ready a=%h got ready=0 exp ready=1 at cyc=%0d", e.a, e.due);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got no finish exp finish", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input bit chk, input logic [31:0] exp);
    valid = 1;
    addr  = {16'h0, a};
    wdata = d;
    wstrb = s;
    sb.push_back('{due: cyc + 1, chk: chk, exp: exp, a: a});
    step();
    valid = 0;
    wstrb = 0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] exp);
    bus(a, 32'h0, 4'h0, 1'b1, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    bus(a, d, s, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    valid = 0;
    wstrb = 0;
    sb.delete();
    repeat (3) step();
    rst_n = 1;
    r = cyc;
  endtask

  task automatic test_reset();
    step();
    rst_n = 0;
    step();
    checks++;
    if (rdy4 !== 1'b0 || rd4 !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus got ready=%b rdata=%h exp ready=0 rdata=0", rdy4, rd4);
    end
    checks++;
    if (tirq4 !== 1'b0 || sirq4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_irpt got timer=%b soft=%b exp 0 0", tirq4, sirq4);
    end
    repeat (2) step();
    rst_n = 1;
    r = cyc;
    checks++;
    if (tirq4 !== 1'b0 || sirq4 !== 1'b0) begin
      failures++;
      $display("FAIL release_irpt got timer=%b soft=%b exp 0 0", tirq4, sirq4);
    end
    rd(16'h0000, 32'h0);
    rd(16'h4000, 32'hffff_ffff);
    rd(16'h4004, 32'hffff_ffff);
    rd(16'hbff8, 32'h0);
    rd(16'hbffc, 32'h0);
  endtask

  task automatic test_timer();
    do_reset();
    wr(16'h4004, 32'h0, 4'hf);
    wr(16'h4000, 32'h3, 4'hf);
    while (cyc < r + 12) step();
    checks++;
    if (tirq4 !== 1'b0) begin
      failures++;
      $display("FAIL timer_early got=%b exp=0", tirq4);
    end
    rd(16'hbff8, 32'h3);
    checks++;
    if (tirq4 !== 1'b1) begin
      failures++;
      $display("FAIL timer_rise got=%b exp=1", tirq4);
    end
    wr(16'h4000, 32'h100, 4'hf);
    checks++;
    if (tirq4 !== 1'b1) begin
      failures++;
      $display("FAIL timer_hold got=%b exp=1", tirq4);
    end
    step();
    checks++;
    if (tirq4 !== 1'b0) begin
      failures++;
      $display("FAIL timer_fall got=%b exp=0", tirq4);
    end
  endtask

  task automatic test_soft();
    wr(16'h0000, 32'h1, 4'hf);
    checks++;
    if (sirq4 !== 1'b1) begin
      failures++;
      $display("FAIL soft_set got=%b exp=1", sirq4);
    end
    rd(16'h0000, 32'h1);
    wr(16'h0000, 32'h0, 4'hf);
    checks++;
    if (sirq4 !== 1'b0) begin
      failures++;
      $display("FAIL soft_clr got=%b exp=0", sirq4);
    end
    rd(16'h0000, 32'h0);
    wr(16'h0000, 32'hffff_ffff, 4'hf);
    rd(16'h0000, 32'h1);
    wr(16'h0000, 32'h0, 4'h2);
    rd(16'h0000, 32'h1);
    wr(16'h0000, 32'h0, 4'hf);
    rd(16'h0000, 32'h0);
  endtask

  task automatic test_carry();
    wr(16'hbffc, 32'h0, 4'hf);
    wr(16'hbff8, 32'hffff_ffff, 4'hf);
    rd(16'hbff8, 32'hffff_ffff);
    while ((cyc - r) % 4 != 0) step();
    rd(16'hbff8, 32'h0);
    rd(16'hbffc, 32'h1);
    wr(16'hbffc, 32'hffff_ffff, 4'hf);
    wr(16'hbff8, 32'hffff_ffff, 4'hf);
    rd(16'hbffc, 32'hffff_ffff);
    checks++;
    if (tirq4 !== 1'b1) begin
      failures++;
      $display("FAIL wrap_irpt_pre got=%b exp=1", tirq4);
    end
    while ((cyc - r) % 4 != 0) step();
    rd(16'hbff8, 32'h0);
    checks++;
    if (tirq4 !== 1'b0) begin
      failures++;
      $display("FAIL wrap_irpt_post got=%b exp=0", tirq4);
    end
    rd(16'hbffc, 32'h0);
  endtask

  task automatic test_lanes();
    do_reset();
    wr(16'h4000, 32'haabb_ccdd, 4'h2);
    rd(16'h4000, 32'hffff_ccff);
    rd(16'h1234, 32'h0);
    wr(16'h1234, 32'hffff_ffff, 4'hf);
    rd(16'h1234, 32'h0);
    rd(16'h0000, 32'h0);
    rd(16'h4000, 32'hffff_ccff);
    rd(16'h4004, 32'hffff_ffff);
  endtask

  task automatic test_collision();
    int c0;
    logic [31:0] base;
    sel = 1;
    do_reset();
    wr(16'hbff8, 32'h10, 4'h1);
    repeat (3) step();
    rd(16'hbff8, 32'h10 + 32'(cyc - r - 1));
    rd(16'hbffc, 32'h0);
    c0 = cyc;
    base = 32'h10 + 32'(c0 - r - 1);
    wr(16'hbff8, 32'h0000_2000, 4'h2);
    base = (base & 32'hffff_00ff) | 32'h0000_2000;
    repeat (2) step();
    rd(16'hbff8, base + 32'(cyc - c0 - 1));
    rd(16'hbff8, base + 32'(cyc - c0 - 1));
    step();
    sel = 0;
  endtask

  task automatic test_back_to_back();
    wr(16'h4004, 32'h1234_5678, 4'hf);
    rd(16'h4004, 32'h1234_5678);
    wr(16'h4004, 32'h0000_00ee, 4'h1);
    rd(16'h4004, 32'h1234_56ee);
    rd(16'h4000, 32'hffff_ccff);
  endtask

  task automatic test_reset_mid();
    wr(16'h0000, 32'h1, 4'hf);
    step();
    valid = 1;
    addr  = 32'h0;
    wstrb = 4'h0;
    @(negedge clk);
    rst_n = 0;
    valid = 0;
    sb.delete();
    #1;
    checks++;
    if (sirq4 !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_soft got=%b exp=0", sirq4);
    end
    step();
    checks++;
    if (rdy4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_drop_ready got=%b exp=0", rdy4);
    end
    step();
    rst_n = 1;
    r = cyc;
    step();
    checks++;
    if (rdy4 !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_ready got=%b exp=0", rdy4);
    end
    rd(16'h0000, 32'h0);
    rd(16'h4004, 32'hffff_ffff);
  endtask

  initial begin
    test_reset();
    test_timer();
    test_soft();
    test_carry();
    test_lanes();
    test_back_to_back();
    test_collision();
    test_reset_mid();
    repeat (2) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clint.md
# clint

Core-local interruptor that produces the `timer_irpt` and `soft_irpt` lines consumed by the machine-mode CSR unit. It holds the memory-mapped `msip`, `mtimecmp` and `mtime` registers behind the core's data-memory request/ready interface. `mtime` advances on a prescaled tick, and the timer interrupt is raised whenever `mtime >= mtimecmp`.

## Interface
- `rtc_div`, default 50: clock cycles per `mtime` increment; legal range 1..65535.
- `clk` input 1: single clock; all state is updated on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `mem_valid` input 1: request strobe, one request per cycle.
- `mem_addr` input 32: byte address; only `[15:0]` is decoded, and the base is decoded upstream.
- `mem_wdata` input 32: write data.
- `mem_wstrb` input 4: byte enables; a non-zero value is a write, zero is a read.
- `mem_rdata` output 32: read data, valid while `mem_ready=1`.
- `mem_ready` output 1: single-cycle response pulse.
- `timer_irpt` output 1: machine timer interrupt (level) to the CSR unit.
- `soft_irpt` output 1: machine software interrupt (level) to the CSR unit.

## Operation
- Register map, word-aligned (`mem_addr[1:0]` ignored):
  - 0x0000 `msip`: bit 0 is read/write; bits 31:1 read 0.
  - 0x4000 `mtimecmp[31:0]`
  - 0x4004 `mtimecmp[63:32]`
  - 0xBFF8 `mtime[31:0]`
  - 0xBFFC `mtime[63:32]`
- Any other offset reads 0. Writes to it are dropped. It still responds.
- Writes apply per byte lane. Each `mem_wstrb[i]` updates byte `i` of the addressed word.
- Prescaler `tick_cnt` is 16-bit:
  - When `tick_cnt == rtc_div-1`, it clears to 0 and `tick` is 1 for that cycle.
  - Otherwise it increments.
  - With `rtc_div=1`, `tick` is 1 every cycle.
- `mtime` update:
  - On `tick`, `mtime <= mtime + 1`, full 64-bit with carry.
  - 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write to an `mtime` word in the same cycle as `tick`:
  - The written bytes of the addressed word take the write data.
  - All other bytes of `mtime` keep their old value, with no increment applied that cycle.
  - The increment resumes on the next `tick`.
- Writes to `mtime` or `mtimecmp` do not affect `tick_cnt`.
- `timer_irpt` is a registered `(mtime >= mtimecmp)`, unsigned 64-bit, evaluated on current register values.
- `soft_irpt` is `msip[0]`, driven straight from its flop.
- Reads return the register value before any write in the same cycle. Reads have no side effects.
- Reset values:
  - `msip = 0`, `mtime = 0`, `mtimecmp = 0xFFFF_FFFF_FFFF_FFFF`, `tick_cnt = 0`.
  - `mem_ready = 0`, `mem_rdata = 0`, `timer_irpt = 0`, `soft_irpt = 0`.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any pending response is discarded and no `mem_ready` is issued for it.

## Timing
- Request accepted in cycle N (`mem_valid=1`):
  - `mem_ready=1` in N+1 only, with `mem_rdata` valid in N+1.
  - `mem_rdata` is 0 whenever `mem_ready=0`.
- Back-to-back requests (N, N+1) give ready in N+1 and N+2. There are no stalls.
- Register write is effective at the end of cycle N; readback on a request in N+1 sees the new value.
- `soft_irpt` changes in N+1 after an `msip` write in N.
- `timer_irpt` changes one cycle after the `mtime`/`mtimecmp` change that flips the compare:
  - `mtime` reaches `mtimecmp` at edge E; `timer_irpt` rises at edge E+1.
  - A write to `mtimecmp` that makes it exceed `mtime` clears `timer_irpt` at N+2.
- A split 32-bit `mtimecmp` update can cause a transient `timer_irpt` assertion. This is architecturally allowed; software writes hi = 0xFFFFFFFF first.

## Test plan
- **Reset:** hold `rst=0` for 3 cycles, then release, then read every map offset -> `msip=0`, `mtimecmp` words = 0xFFFFFFFF, `mtime` ≈ 0, both irpt lines 0.
- **Software interrupt:** write `msip=0x1` in cycle N -> `mem_ready` in N+1, `soft_irpt=1` in N+1. Write 0 -> `soft_irpt=0` one cycle later. A read returns 0x1 and then 0x0.
- **Timer compare:** `rtc_div=4`; write `mtimecmp` hi=0, lo=3 -> `mtime` becomes 3 exactly 12 cycles after reset release, and `timer_irpt` rises 1 cycle later. Write lo=0x100 -> `timer_irpt` falls 2 cycles after the write request.
- **Carry and wrap:**
  - Write `mtime` lo=0xFFFFFFFF, hi=0 -> after the next tick, reads give hi=1, lo=0.
  - Preload `mtime` = all ones -> it wraps to 0.
- **Write/tick collision:** `rtc_div=1`; write `mtime` lo=0x10 with `wstrb=0x1` -> the next read of lo is 0x10 + elapsed ticks, with no lost or extra increment.
- **Byte lanes and unmapped address:**
  - `wstrb=0x2` with data 0xAABBCCDD to `mtimecmp` lo (reset 0xFFFFFFFF) -> reads 0xFFFFCCFF.
  - Access to 0x1234 -> ready in 1 cycle, rdata 0, no state change.
  - Assert `rst` one cycle after a request -> no `mem_ready` is issued.
